// File: rtl/xram_pkg.sv
// Shared types and constants for the XRAM responder.
//   xram_state_e      : access FSM states (IDLE, WAIT, ACK)
//   XRAM_*_DEF        : default parameter values for xram_responder
//   XRAM_RD_FILL      : byte returned by an out-of-range read
//   xram_in_range()   : 17-bit, non-wrapping window test
package xram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } xram_state_e;

  localparam int unsigned XRAM_MEM_BYTES_DEF = 1024;
  localparam logic [15:0] XRAM_ADDR_BASE_DEF = 16'h0000;
  localparam int unsigned XRAM_LATENCY_DEF   = 2;
  localparam logic [7:0]  XRAM_RD_FILL       = 8'hFF;

  // Widened to 17 bits so a window ending at 16'hFFFF+1 does not wrap to 0.
  function automatic logic xram_in_range(input logic [15:0] addr, input logic [15:0] base,
                                         input int unsigned bytes);
    logic [16:0] a;
    logic [16:0] lo;
    logic [16:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + 17'(bytes);
    return (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/xram_sp_mem.sv
// Single-port byte storage for the XRAM responder.
// Synchronous write, combinational read, no reset (contents survive rst).
// Ports:
//   clk     : clock
//   we_i    : write enable
//   addr_i  : byte offset, AW bits
//   wdata_i : write byte
//   rdata_o : read byte at addr_i
module xram_sp_mem #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/xram_responder.sv
// XRAM slave: serves byte reads/writes from an internal memory with a
// programmable number of wait cycles before a one-cycle ack.
// Optional macro XRAM_RANGE_CHECK_EN: out-of-range accesses still ack, reads
// return 8'hFF, writes are dropped and xram_err latches until rst. Without it
// the offset wraps modulo MEM_BYTES and xram_err is 0.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   xram_stb       : request, held until ack
//   xram_wr        : 1 = write, 0 = read
//   xram_addr      : byte address
//   xram_data_out  : write data from initiator
//   xram_data_in   : registered read data, held until next read ack
//   xram_ack       : one-cycle completion pulse
//   xram_err       : sticky out-of-range flag
//   rd_count       : completed reads, saturating
//   wr_count       : completed writes, saturating
module xram_responder
  import xram_pkg::*;
#(
  parameter int unsigned MEM_BYTES = XRAM_MEM_BYTES_DEF,
  parameter logic [15:0] ADDR_BASE = XRAM_ADDR_BASE_DEF,
  parameter int unsigned LATENCY   = XRAM_LATENCY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        xram_stb,
  input  logic        xram_wr,
  input  logic [15:0] xram_addr,
  input  logic [7:0]  xram_data_out,
  output logic [7:0]  xram_data_in,
  output logic        xram_ack,
  output logic        xram_err,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int unsigned AW  = $clog2(MEM_BYTES);
  localparam logic [3:0]  LAT = 4'(LATENCY);

  xram_state_e state;
  logic [3:0]  wait_cnt;
  logic [15:0] addr_q;
  logic        wr_q;
  logic [7:0]  wdata_q;
  logic        ack_q;
  logic [7:0]  rdata_q;
  logic [15:0] rd_cnt_q;
  logic [15:0] wr_cnt_q;

  logic [15:0]   cur_addr;
  logic [15:0]   cur_off;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic [7:0]    rd_byte;
  logic          acc_ok;
  logic          mem_we;
  logic          unused_off;

  // In IDLE the live address feeds the memory so a zero-latency read can
  // register its data on the capture edge; otherwise the captured address.
  assign cur_addr   = (state == IDLE) ? xram_addr : addr_q;
  assign cur_off    = cur_addr - ADDR_BASE;
  assign mem_addr   = cur_off[AW-1:0];
  assign unused_off = ^cur_off[15:AW];

`ifdef XRAM_RANGE_CHECK_EN
  assign acc_ok = xram_in_range(cur_addr, ADDR_BASE, MEM_BYTES);
`else
  assign acc_ok = 1'b1;
`endif

  assign rd_byte = acc_ok ? mem_rdata : XRAM_RD_FILL;
  // Commit on the edge that ends ACK; rst in that cycle suppresses it.
  assign mem_we  = (state == ACK) && wr_q && acc_ok && !rst;

  xram_sp_mem #(
    .DEPTH(MEM_BYTES),
    .AW   (AW)
  ) u_mem (
    .clk    (clk),
    .we_i   (mem_we),
    .addr_i (mem_addr),
    .wdata_i(wdata_q),
    .rdata_o(mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      ack_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (xram_stb) begin
            addr_q  <= xram_addr;
            wr_q    <= xram_wr;
            wdata_q <= xram_data_out;
            if (LATENCY == 0) begin
              state    <= ACK;
              ack_q    <= 1'b1;
              wait_cnt <= '0;
              if (!xram_wr) rdata_q <= rd_byte;
            end else begin
              state    <= WAIT;
              wait_cnt <= LAT;
            end
          end
        end
        WAIT: begin
          if (!xram_stb) begin
            // Initiator withdrew: abandon silently.
            state    <= IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
            if (wait_cnt == 4'd1) begin
              state <= ACK;
              ack_q <= 1'b1;
              if (!wr_q) rdata_q <= rd_byte;
            end
          end
        end
        ACK: begin
          state <= IDLE;
          if (wr_q) begin
            if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
          end else begin
            if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef XRAM_RANGE_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((state == ACK) && !acc_ok) begin
      err_q <= 1'b1;
    end
  end
  assign xram_err = err_q;
`else
  assign xram_err = 1'b0;
`endif

  assign xram_data_in = rdata_q;
  assign xram_ack     = ack_q;
  assign rd_count     = rd_cnt_q;
  assign wr_count     = wr_cnt_q;

endmodule
